// File: rtl/add_tree_acc_pkg.sv
// Shared arithmetic types and helpers for the add_tree_acc block: fixed-point config,
// width conversion with saturate/wrap, and the tree-depth helpers.
package add_tree_acc_pkg;

  typedef enum logic [1:0] {
    FIXED_POINT_GENERIC,
    FIXED_POINT_Q,
    FLOATING_POINT
  } arith_type_e;

  typedef struct packed {
    int int_wdt;
    int frac_wdt;
  } fxp_cfg_t;

  typedef struct packed {
    int          word_wdt;
    fxp_cfg_t    fxp_cfg;
    arith_type_e arith_type;
    logic        arith_satur;
  } arith_cfg_t;

  localparam arith_cfg_t ARITH_CFG_DEFAULT = '{
    word_wdt:    16,
    fxp_cfg:     '{int_wdt: 8, frac_wdt: 8},
    arith_type:  FIXED_POINT_GENERIC,
    arith_satur: 1'b1
  };

  // Widest value sat_wdt can carry; accumulator widths must stay below this.
  localparam int SAT_MAX_WDT = 64;

  typedef struct packed {
    logic [SAT_MAX_WDT-1:0] res;
    logic                   ovf;
  } sat_res_t;

  // Reinterpret the low from_wdt bits of value as signed, then fit them into to_wdt
  // bits. ovf flags an out-of-range value whether or not it is clamped.
  function automatic sat_res_t sat_wdt(input logic [SAT_MAX_WDT-1:0] value,
                                       input int from_wdt, input int to_wdt,
                                       input logic satur);
    logic signed [SAT_MAX_WDT-1:0] v;
    logic signed [SAT_MAX_WDT-1:0] max_v;
    logic signed [SAT_MAX_WDT-1:0] min_v;
    sat_res_t r;
    v     = $signed(value << (SAT_MAX_WDT - from_wdt)) >>> (SAT_MAX_WDT - from_wdt);
    max_v = (64'sd1 <<< (to_wdt - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (to_wdt - 1));
    r.ovf = (v > max_v) || (v < min_v);
    if (satur && r.ovf) r.res = v[SAT_MAX_WDT-1] ? min_v : max_v;
    else                r.res = v;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int tree_lvl_cnt(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/add_tree_acc_if.sv
// Operand/result bundle of add_tree_acc; the producer/consumer side uses master.
interface add_tree_acc_if #(
  parameter int OP_CNT   = 4,
  parameter int WORD_WDT = 16
);
  logic [OP_CNT*WORD_WDT-1:0] add_op_vec;
  logic                       add_op_val;
  logic                       add_op_first;
  logic                       add_op_last;
  logic [WORD_WDT-1:0]        add_res;
  logic                       add_res_val;
  logic                       add_res_ovf;

  modport master (
    output add_op_vec, add_op_val, add_op_first, add_op_last,
    input  add_res, add_res_val, add_res_ovf
  );

  modport slave (
    input  add_op_vec, add_op_val, add_op_first, add_op_last,
    output add_res, add_res_val, add_res_ovf
  );
endinterface

// File: rtl/add_tree_acc_lvl.sv
// One registered level of the adder tree: adjacent pairs are summed one bit wider,
// so a level can never overflow. Beat framing travels alongside the data.
module add_tree_lvl #(
  parameter int IN_CNT = 4,
  parameter int IN_WDT = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic [IN_CNT*IN_WDT-1:0]              in_vec,
  input  logic                                  in_val,
  input  logic                                  in_first,
  input  logic                                  in_last,
  output logic [(IN_CNT/2)*(IN_WDT+1)-1:0]      out_vec,
  output logic                                  out_val,
  output logic                                  out_first,
  output logic                                  out_last
);
  localparam int OUT_CNT = IN_CNT / 2;
  localparam int OUT_WDT = IN_WDT + 1;

  logic [OUT_CNT*OUT_WDT-1:0] sum;

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves sum unassigned (latch).
    sum = '0;
    for (int i = 0; i < OUT_CNT; i++) begin
      sum[i*OUT_WDT +: OUT_WDT] = OUT_WDT'($signed(in_vec[(2*i)*IN_WDT +: IN_WDT]))
                                + OUT_WDT'($signed(in_vec[(2*i+1)*IN_WDT +: IN_WDT]));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all levels update together.
    if (rst) begin
      out_vec   <= '0;
      out_val   <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (clk_en) begin
      out_vec   <= sum;
      out_val   <= in_val;
      out_first <= in_first;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/add_tree_acc.sv
// Pipelined signed adder tree with optional first/last-framed burst accumulator and
// saturating or wrapping conversion back to the word width.
module add_tree_acc import add_tree_acc_pkg::*; #(
  parameter arith_cfg_t ADD_ARITH_CFG   = ARITH_CFG_DEFAULT,
  parameter int         ADD_OP_CNT      = 4,
  parameter int         ADD_IN_CYC_LEN  = 1,
  parameter int         ADD_OUT_CYC_LEN = 1,
  parameter bit         ACC_EN          = 1'b1,
  parameter int         ACC_GUARD_WDT   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  add_tree_acc_if.slave bus
);
  localparam int W     = ADD_ARITH_CFG.word_wdt;
  localparam int D     = tree_lvl_cnt(ADD_OP_CNT);
  localparam int TW    = W + D;
  localparam int AW    = TW + ACC_GUARD_WDT;
  localparam bit SATUR = ADD_ARITH_CFG.arith_satur;

  if (ADD_ARITH_CFG.arith_type != FIXED_POINT_GENERIC) begin : g_chk_type
    $fatal(1, "add_tree_acc: only FIXED_POINT_GENERIC is supported");
  end
  if (!is_pow2(ADD_OP_CNT) || ADD_OP_CNT < 2) begin : g_chk_cnt
    $fatal(1, "add_tree_acc: ADD_OP_CNT must be a power of two >= 2");
  end
  if (ADD_IN_CYC_LEN < 0 || ADD_OUT_CYC_LEN < 1) begin : g_chk_cyc
    $fatal(1, "add_tree_acc: bad pipeline stage counts");
  end

  typedef struct packed {
    logic                    val;
    logic                    first;
    logic                    last;
    logic [ADD_OP_CNT*W-1:0] vec;
  } beat_t;

  typedef struct packed {
    logic         val;
    logic         ovf;
    logic [W-1:0] res;
  } out_t;

  beat_t in_beat;
  beat_t tree_in;

  // Framing is meaningless without valid, so it is dropped at the door.
  assign in_beat = '{val:   bus.add_op_val,
                     first: bus.add_op_val & bus.add_op_first,
                     last:  bus.add_op_val & bus.add_op_last,
                     vec:   bus.add_op_vec};

  if (ADD_IN_CYC_LEN == 0) begin : g_in_bypass
    assign tree_in = in_beat;
  end else begin : g_in_pipe
    beat_t pipe_q [ADD_IN_CYC_LEN];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < ADD_IN_CYC_LEN; i++) pipe_q[i] <= '0;
      end else if (clk_en) begin
        pipe_q[0] <= in_beat;
        for (int i = 1; i < ADD_IN_CYC_LEN; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign tree_in = pipe_q[ADD_IN_CYC_LEN-1];
  end

  for (genvar k = 0; k < D; k++) begin : g_lvl
    localparam int IN_CNT = ADD_OP_CNT >> k;
    localparam int IN_WDT = W + k;
    logic [IN_CNT*IN_WDT-1:0]         in_vec;
    logic                             in_val, in_first, in_last;
    logic [(IN_CNT/2)*(IN_WDT+1)-1:0] out_vec;
    logic                             out_val, out_first, out_last;

    if (k == 0) begin : g_src
      assign in_vec   = tree_in.vec;
      assign in_val   = tree_in.val;
      assign in_first = tree_in.first;
      assign in_last  = tree_in.last;
    end else begin : g_src
      assign in_vec   = g_lvl[k-1].out_vec;
      assign in_val   = g_lvl[k-1].out_val;
      assign in_first = g_lvl[k-1].out_first;
      assign in_last  = g_lvl[k-1].out_last;
    end

    add_tree_lvl #(.IN_CNT(IN_CNT), .IN_WDT(IN_WDT)) u_lvl (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .in_vec(in_vec), .in_val(in_val), .in_first(in_first), .in_last(in_last),
      .out_vec(out_vec), .out_val(out_val), .out_first(out_first), .out_last(out_last)
    );
  end

  logic [TW-1:0] root;
  logic          root_val, root_first, root_last;
  out_t          pre_out;

  assign root       = g_lvl[D-1].out_vec;
  assign root_val   = g_lvl[D-1].out_val;
  assign root_first = g_lvl[D-1].out_first;
  assign root_last  = g_lvl[D-1].out_last;

  if (!ACC_EN) begin : g_no_acc
    sat_res_t conv;
    logic     unused_bits;
    always_comb begin
      conv    = sat_wdt(SAT_MAX_WDT'($signed(root)), TW, W, SATUR);
      pre_out = '{val: root_val, ovf: conv.ovf, res: conv.res[W-1:0]};
    end
    assign unused_bits = ^{root_first, root_last, conv.res[SAT_MAX_WDT-1:W]};
  end else begin : g_acc
    localparam int SW = AW + 1;
    logic [AW-1:0] acc_q;
    logic          sticky_q;
    out_t          acc_out_q;
    logic [AW-1:0] acc_base;
    logic [SW-1:0] acc_sum;
    logic          sticky_next;
    sat_res_t      acc_sat;
    sat_res_t      res_sat;
    logic          unused_bits;

    // A beat carrying first restarts from zero, which also discards any open burst.
    always_comb begin
      acc_base    = root_first ? '0 : acc_q;
      acc_sum     = SW'($signed(acc_base)) + SW'($signed(root));
      acc_sat     = sat_wdt(SAT_MAX_WDT'($signed(acc_sum)), SW, AW, 1'b1);
      sticky_next = (root_first ? 1'b0 : sticky_q) | acc_sat.ovf;
      res_sat     = sat_wdt(SAT_MAX_WDT'($signed(acc_sat.res[AW-1:0])), AW, W, SATUR);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q     <= '0;
        sticky_q  <= 1'b0;
        acc_out_q <= '0;
      end else if (clk_en) begin
        acc_out_q.val <= root_val & root_last;
        if (root_val) begin
          if (root_last) begin
            acc_q         <= '0;
            sticky_q      <= 1'b0;
            acc_out_q.res <= res_sat.res[W-1:0];
            acc_out_q.ovf <= sticky_next | res_sat.ovf;
          end else begin
            acc_q    <= acc_sat.res[AW-1:0];
            sticky_q <= sticky_next;
          end
        end
      end
    end

    assign pre_out     = acc_out_q;
    assign unused_bits = ^{acc_sat.res[SAT_MAX_WDT-1:AW], res_sat.res[SAT_MAX_WDT-1:W]};
  end

  out_t out_q [ADD_OUT_CYC_LEN];

  // Data only moves with valid so add_res holds its last value between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every stage element is reset so beats in flight at rst never surface.
      for (int i = 0; i < ADD_OUT_CYC_LEN; i++) out_q[i] <= '0;
    end else if (clk_en) begin
      out_q[0].val <= pre_out.val;
      if (pre_out.val) begin
        out_q[0].res <= pre_out.res;
        out_q[0].ovf <= pre_out.ovf;
      end
      for (int i = 1; i < ADD_OUT_CYC_LEN; i++) begin
        out_q[i].val <= out_q[i-1].val;
        if (out_q[i-1].val) begin
          out_q[i].res <= out_q[i-1].res;
          out_q[i].ovf <= out_q[i-1].ovf;
        end
      end
    end
  end

  assign bus.add_res     = out_q[ADD_OUT_CYC_LEN-1].res;
  assign bus.add_res_val = out_q[ADD_OUT_CYC_LEN-1].val;
  assign bus.add_res_ovf = out_q[ADD_OUT_CYC_LEN-1].ovf;

endmodule

// File: tb/tb_add_tree_acc.sv
// Directed bench for add_tree_acc: three instances (saturating, wrapping, accumulating)
// share one stimulus stream; a reference model fills per-instance scoreboards.
module tb_add_tree_acc;
  import add_tree_acc_pkg::*;

  localparam int W        = 16;
  localparam int N        = 4;
  localparam int LAT_TREE = 1 + 2 + 1;
  localparam int LAT_ACC  = 1 + 2 + 1 + 1;
  localparam longint ACC_MAX = (64'sd1 <<< 25) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 25);

  localparam arith_cfg_t CFG_SAT  = ARITH_CFG_DEFAULT;
  localparam arith_cfg_t CFG_WRAP = '{word_wdt: 16, fxp_cfg: '{int_wdt: 8, frac_wdt: 8},
                                      arith_type: FIXED_POINT_GENERIC, arith_satur: 1'b0};

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic [N*W-1:0] op_vec;
  logic op_val, op_first, op_last;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t q [3][$];
  longint acc_m;
  bit sticky_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_tree_acc_if #(.OP_CNT(N), .WORD_WDT(W)) bus_sat  ();
  add_tree_acc_if #(.OP_CNT(N), .WORD_WDT(W)) bus_wrap ();
  add_tree_acc_if #(.OP_CNT(N), .WORD_WDT(W)) bus_acc  ();

  assign bus_sat.add_op_vec    = op_vec;
  assign bus_sat.add_op_val    = op_val;
  assign bus_sat.add_op_first  = op_first;
  assign bus_sat.add_op_last   = op_last;
  assign bus_wrap.add_op_vec   = op_vec;
  assign bus_wrap.add_op_val   = op_val;
  assign bus_wrap.add_op_first = op_first;
  assign bus_wrap.add_op_last  = op_last;
  assign bus_acc.add_op_vec    = op_vec;
  assign bus_acc.add_op_val    = op_val;
  assign bus_acc.add_op_first  = op_first;
  assign bus_acc.add_op_last   = op_last;

  add_tree_acc #(.ADD_ARITH_CFG(CFG_SAT), .ADD_OP_CNT(N), .ADD_IN_CYC_LEN(1),
                 .ADD_OUT_CYC_LEN(1), .ACC_EN(1'b0), .ACC_GUARD_WDT(8))
    dut_sat (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_sat));

  add_tree_acc #(.ADD_ARITH_CFG(CFG_WRAP), .ADD_OP_CNT(N), .ADD_IN_CYC_LEN(1),
                 .ADD_OUT_CYC_LEN(1), .ACC_EN(1'b0), .ACC_GUARD_WDT(8))
    dut_wrap (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_wrap));

  add_tree_acc #(.ADD_ARITH_CFG(CFG_SAT), .ADD_OP_CNT(N), .ADD_IN_CYC_LEN(1),
                 .ADD_OUT_CYC_LEN(1), .ACC_EN(1'b1), .ACC_GUARD_WDT(8))
    dut_acc (.clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus_acc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon(input int idx, input logic v, input logic [W-1:0] r, input logic o);
    exp_t e;
    if (v) begin
      if (q[idx].size() == 0) begin
        check($sformatf("unexpected_val dut%0d", idx), 32'(v), 32'd0);
      end else begin
        e = q[idx].pop_front();
        check($sformatf("res dut%0d", idx), 32'(r), 32'(e.res));
        check($sformatf("ovf dut%0d", idx), 32'(o), 32'(e.ovf));
        check($sformatf("cycle dut%0d", idx), cyc, e.cyc);
      end
    end
  endtask

  // A result is consumed on an edge where clk_en is high; inputs change just after posedge.
  always @(negedge clk) begin
    if (clk_en) begin
      mon(0, bus_sat.add_res_val,  bus_sat.add_res,  bus_sat.add_res_ovf);
      mon(1, bus_wrap.add_res_val, bus_wrap.add_res, bus_wrap.add_res_ovf);
      mon(2, bus_acc.add_res_val,  bus_acc.add_res,  bus_acc.add_res_ovf);
    end
  end

  function automatic logic [W-1:0] clamp16(input longint s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[W-1:0];
  endfunction

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] d, input logic first, input logic last);
    longint s;
    logic   rng;
    exp_t   e;
    op_vec   = {d, c, b, a};
    op_val   = 1'b1;
    op_first = first;
    op_last  = last;
    s   = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c)) + longint'($signed(d));
    rng = (s > 32767) || (s < -32768);
    e = '{res: clamp16(s), ovf: rng, cyc: cyc + LAT_TREE};
    q[0].push_back(e);
    e = '{res: s[W-1:0], ovf: rng, cyc: cyc + LAT_TREE};
    q[1].push_back(e);
    if (first) begin
      acc_m    = 0;
      sticky_m = 1'b0;
    end
    acc_m = acc_m + s;
    if (acc_m > ACC_MAX) begin acc_m = ACC_MAX; sticky_m = 1'b1; end
    if (acc_m < ACC_MIN) begin acc_m = ACC_MIN; sticky_m = 1'b1; end
    if (last) begin
      e = '{res: clamp16(acc_m), ovf: sticky_m | (acc_m > 32767) | (acc_m < -32768),
            cyc: cyc + LAT_ACC};
      q[2].push_back(e);
      acc_m    = 0;
      sticky_m = 1'b0;
    end
    @(posedge clk); #1;
    op_val   = 1'b0;
    op_first = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Everything still due from now on arrives n cycles later.
  task automatic stall(input int n);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < q[i].size(); j++)
        if (q[i][j].cyc >= cyc) q[i][j].cyc = q[i][j].cyc + n;
    clk_en = 1'b0;
    idle(n);
    clk_en = 1'b1;
  endtask

  // Results due after the reset edge are discarded by the DUT, so drop them here too.
  task automatic pulse_reset();
    int c;
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      exp_t keep[$];
      keep = {};
      for (int j = 0; j < q[i].size(); j++)
        if (q[i][j].cyc <= c) keep.push_back(q[i][j]);
      q[i] = keep;
    end
    acc_m    = 0;
    sticky_m = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst res_val sat", 32'(bus_sat.add_res_val), 32'd0);
    check("rst res_val acc", 32'(bus_acc.add_res_val), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b1;
    op_vec   = '0;
    op_val   = 1'b0;
    op_first = 1'b0;
    op_last  = 1'b0;
    acc_m    = 0;
    sticky_m = 1'b0;
    idle(2);
    rst = 1'b0;
    check("reset res sat",  32'(bus_sat.add_res),      32'd0);
    check("reset val sat",  32'(bus_sat.add_res_val),  32'd0);
    check("reset ovf sat",  32'(bus_sat.add_res_ovf),  32'd0);
    check("reset res acc",  32'(bus_acc.add_res),      32'd0);
    check("reset val acc",  32'(bus_acc.add_res_val),  32'd0);
    check("reset ovf wrap", 32'(bus_wrap.add_res_ovf), 32'd0);

    // Plain reduction of mixed-sign operands.
    beat(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b1, 1'b1);
    idle(6);
    check("hold res sat", 32'(bus_sat.add_res), 32'h0280);

    // Positive and negative overflow, saturated and wrapped.
    beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b1, 1'b1);
    beat(16'h9000, 16'h9000, 16'h9000, 16'h9000, 1'b1, 1'b1);
    idle(6);

    // Three-beat burst, then a single-beat burst with no carry-over.
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0);
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0);
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1);
    beat(16'h0080, 16'h0080, 16'h0080, 16'h0080, 1'b1, 1'b1);
    idle(7);

    // Overflowing burst, then sticky flag must be gone for the next one.
    beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b1, 1'b0);
    beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b0, 1'b0);
    beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 1'b0, 1'b1);
    beat(16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b1, 1'b1);
    idle(7);

    // Stall while the beat is inside the tree.
    beat(16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b1, 1'b1);
    idle(1);
    stall(3);
    idle(8);

    // Reset mid-burst, then a last-only beat starts from zero.
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0);
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0);
    pulse_reset();
    beat(16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1);
    idle(8);

    for (int i = 0; i < 3; i++) check($sformatf("drained dut%0d", i), q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_tree_acc.md
Name: add_tree_acc

Overview:
Parametrised successor of the single-pair fixed-point adder. It reduces ADD_OP_CNT signed fixed-point operands per beat through a pipelined binary adder tree. An optional accumulator sums tree results across a first/last-framed burst of beats. The final result is saturated or wrapped to word_wdt, and a sticky overflow flag is reported. It sits in the systolic array output path, reducing partial sums from parallel PE columns and accumulating across input-channel tiles.

Parameters:
ADD_ARITH_CFG, '{word_wdt:16, fxp_cfg:'{int_wdt:8, frac_wdt:8}, arith_type:FIXED_POINT_GENERIC, arith_satur:1}, arithmetic config for operands and result; only FIXED_POINT_GENERIC is supported (elaboration error otherwise).
ADD_OP_CNT, 4, operands per beat; power of two, >= 2 (elaboration error otherwise).
ADD_IN_CYC_LEN, 1, input register stages (>= 0).
ADD_OUT_CYC_LEN, 1, output register stages (>= 1).
ACC_EN, 1, 1 = accumulate across burst, 0 = one result per beat.
ACC_GUARD_WDT, 8, extra accumulator guard bits.

Ports:
clk  in  1  clock
rst  in  1  reset
clk_en  in  1  global stall; 0 freezes every register, including valids
add_op_vec  in  ADD_OP_CNT*W  packed operands, operand i at [i*W+:W], two's complement
add_op_val  in  1  beat valid
add_op_first  in  1  first beat of burst (used only if ACC_EN)
add_op_last  in  1  last beat of burst (used only if ACC_EN)
add_res  out  W  result
add_res_val  out  1  result valid, one-cycle pulse per result
add_res_ovf  out  1  overflow/saturation occurred in this result; qualified by add_res_val

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- W = word_wdt; D = clog2(ADD_OP_CNT); TW = W+D; AW = TW+ACC_GUARD_WDT.
- Reset (rst=1 at a clk edge, regardless of clk_en): all pipeline data, valids and flags are cleared, and the accumulator is set to 0. add_res=0, add_res_val=0, add_res_ovf=0. In-flight beats are discarded and no result appears for them. A burst open at reset is closed.
- Tree: D register levels. Level k adds adjacent pairs sign-extended by 1 bit, so there is no overflow inside the tree. The root is a TW-bit exact sum.
- first/last travel with valid through the pipeline. They are ignored when valid=0.
- ACC_EN=0:
  - Root is saturated (arith_satur=1) or truncated to the low W bits (arith_satur=0) in the final stage.
  - ovf=1 if the root is outside the signed W-bit range, in both modes.
  - Latency from add_op_val to add_res_val is ADD_IN_CYC_LEN+D+ADD_OUT_CYC_LEN cycles.
- ACC_EN=1 accumulator stage (1 cycle, AW bits) on a valid beat:
  - acc_next = (first ? 0 : acc) + sext(root).
  - acc saturates at the AW range, which sets the sticky ovf.
  - The sticky ovf is cleared with the acc term on first.
- Beat without first while no burst is open: adds to acc, which is 0 after reset or after last, so this is legal and identical to first.
- first and last on the same beat: single-beat burst.
- first while a burst is open: the old burst is silently discarded and a new burst starts.
- On last: acc is converted to W bits exactly as in ACC_EN=0 (saturate or wrap, ovf OR-ed into sticky) and emitted. Then acc=0 and sticky=0 on the same edge.
  - Latency from the last beat to add_res_val is ADD_IN_CYC_LEN+D+1+ADD_OUT_CYC_LEN cycles.
  - Non-last beats produce no add_res_val.
- Throughput: one beat per cycle, no backpressure.
- clk_en=0: every register holds, including add_res and add_res_val. A held valid therefore stays high while stalled. Consumers qualify with clk_en; no duplicate results are produced on resume.
- Between valid pulses add_res holds its last value.

Decomposition:
- arith_pckg additions: function sat_wdt(value, from_wdt, to_wdt, satur) returning result and ovf; function is_pow2; tree_lvl_cnt(ADD_OP_CNT) constant helper.
- Sub-module add_tree_lvl: one tree level. Parameters IN_CNT and IN_WDT; pairwise sign-extended add, register with clk_en/rst, carries valid/first/last.
- The top instantiates D levels via generate, and implements the accumulator, output conversion and delay stages in-block.

Test Plan:
1. ACC_EN=0, N=4, Q8.8, ops {0x0100,0x0200,0xFF00,0x0080}, val 1 cycle -> add_res=0x0280, ovf=0, add_res_val pulses exactly 4 cycles later.
2. ACC_EN=0, satur=1: 4x0x7000 -> 0x7FFF, ovf=1; 4x0x9000 -> 0x8000, ovf=1. With satur=0: 4x0x7000 -> 0xC000, ovf=1.
3. ACC_EN=1: three back-to-back beats of 4x0x0100, first on beat 0, last on beat 2 -> single result 0x0C00, ovf=0, 5 cycles after the last beat. The next burst {first+last, 4x0x0080} -> 0x0200, with no carry-over.
4. ACC_EN=1: burst of 3 beats of 4x0x7000 -> 0x7FFF, ovf=1. The following burst of 4x0x0001 -> 0x0004, ovf=0 (sticky cleared).
5. Stall: clk_en=0 for 3 cycles while test-1 data is mid-tree -> same 0x0280, add_res_val delayed by 3 cycles, exactly one result after resume.
6. rst pulse mid-burst (after 2 of 3 beats) -> no add_res_val. The next beat 4x0x0100 with last but without first -> 0x0400.
